vx_tensor_commit_seq: RTL and testbench

Parametrised commit sequencer for a tensor-core issue slice. It tracks per-uop metadata from dispatch, joins NUM_UNITS lockstep compute units' result handshakes into one registered result buffer, and serialises each result into NUM_BEATS commit beats. It sits between the tensor compute units and the commit interface. It adds the following over the fixed two-beat sequencer:
- generic beat, unit, lane and depth parameters
- credit-limited dispatch backpressure
- commit-side stall tolerance
- sticky lockstep-skew and metadata-underflow error flags

---
 rtl/vx_tensor_commit_seq.sv | 156 +++++++++++++++
 tb/tb_vx_tensor_commit_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tensor_commit_seq.sv
// Tensor-slice commit sequencer: tracks dispatched uop metadata, joins lockstep
// unit results into one buffer, and streams each result out as NUM_BEATS beats.
module vx_tensor_commit_seq #(
    parameter int unsigned NUM_LANES   = 32,
    parameter int unsigned DATAW       = 32,
    parameter int unsigned META_W      = 64,
    parameter int unsigned NUM_BEATS   = 2,
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned SKEW_MAX    = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 disp_valid,
    output logic                                 disp_ready,
    input  logic [META_W-1:0]                    disp_meta,
    input  logic [NUM_UNITS-1:0]                 unit_valid,
    output logic [NUM_UNITS-1:0]                 unit_ready,
    input  logic [NUM_BEATS*NUM_LANES*DATAW-1:0] unit_data,
    output logic                                 commit_valid,
    input  logic                                 commit_ready,
    output logic [META_W-1:0]                    commit_meta,
    output logic [NUM_LANES*DATAW-1:0]           commit_data,
    output logic                                 commit_eop,
    output logic [$clog2(MAX_PENDING):0]         pending_count,
    output logic                                 err_skew,
    output logic                                 err_underflow
);

    localparam int unsigned BeatW = NUM_LANES * DATAW;
    localparam int unsigned CntW  = $clog2(MAX_PENDING) + 1;
    localparam int unsigned PtrW  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned IdxW  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned SkewW = (SKEW_MAX > 0) ? $clog2(SKEW_MAX + 1) : 1;

    localparam logic [IdxW-1:0]  LastBeat = IdxW'(NUM_BEATS - 1);
    localparam logic [CntW-1:0]  MaxPend  = CntW'(MAX_PENDING);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(MAX_PENDING - 1);
    localparam logic [SkewW-1:0] SkewLim  = SkewW'(SKEW_MAX);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [META_W-1:0] meta_mem [MAX_PENDING];
    logic [BeatW-1:0]  buf_q [NUM_BEATS];
    logic              full_q, full_d;
    logic [IdxW-1:0]   beat_q, beat_d;
    logic [SkewW-1:0]  skew_q, skew_d;
    logic              err_skew_q, err_skew_d;
    logic              err_uf_q, err_uf_d;

    logic all_v, partial_v, disp_fire, commit_fire, last_beat, buf_free, capture;

    // Handshake decode; FIFO occupancy equals pending_count since every beat pops one entry.
    always_comb begin
        all_v        = &unit_valid;
        partial_v    = (|unit_valid) && !all_v;
        disp_ready   = cnt_q < MaxPend;
        disp_fire    = disp_valid && disp_ready;
        commit_valid = full_q && (cnt_q != '0);
        commit_fire  = commit_valid && commit_ready;
        last_beat    = beat_q == LastBeat;
        // Buffer counts as free if its last beat leaves this cycle, so results chain bubble-free.
        buf_free     = !full_q || (commit_fire && last_beat);
        capture      = all_v && buf_free && !reset;
        unit_ready   = {NUM_UNITS{capture}};
        commit_meta  = meta_mem[rd_q];
        commit_data  = buf_q[beat_q];
        commit_eop   = commit_valid && last_beat;
        pending_count = cnt_q;
        err_skew      = err_skew_q;
        err_underflow = err_uf_q;
    end

    // Next-state for counters, pointers, beat position and sticky flags.
    always_comb begin
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        full_d     = full_q;
        beat_d     = beat_q;
        skew_d     = '0;
        err_skew_d = err_skew_q;
        err_uf_d   = err_uf_q || (full_q && (cnt_q == '0));

        unique case ({disp_fire, commit_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (disp_fire) begin
            wr_d = (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
        end

        if (commit_fire) begin
            rd_d = (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
            if (last_beat) begin
                beat_d = '0;
                full_d = 1'b0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        if (capture) begin
            full_d = 1'b1;
        end

        if (partial_v) begin
            skew_d = (skew_q >= SkewLim) ? skew_q : skew_q + 1'b1;
            if (skew_d >= SkewLim) begin
                err_skew_d = 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            full_q     <= 1'b0;
            beat_q     <= '0;
            skew_q     <= '0;
            err_skew_q <= 1'b0;
            err_uf_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            full_q     <= full_d;
            beat_q     <= beat_d;
            skew_q     <= skew_d;
            err_skew_q <= err_skew_d;
            err_uf_q   <= err_uf_d;
        end
    end

    // Metadata FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            meta_mem[wr_q] <= disp_meta;
        end
    end

    // Result buffer storage, split per beat.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                buf_q[b] <= unit_data[b*BeatW +: BeatW];
            end
        end
    end

endmodule

// File: tb/tb_vx_tensor_commit_seq.sv
// Directed bench for vx_tensor_commit_seq at default parameters.
module tb_vx_tensor_commit_seq;

    localparam int NL = 32;
    localparam int DW = 32;
    localparam int MW = 64;
    localparam int NB = 2;
    localparam int NU = 4;
    localparam int LW = NL * DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            disp_valid = 1'b0;
    logic            disp_ready;
    logic [MW-1:0]   disp_meta = '0;
    logic [NU-1:0]   unit_valid = '0;
    logic [NU-1:0]   unit_ready;
    logic [NB*LW-1:0] unit_data = '0;
    logic            commit_valid;
    logic            commit_ready = 1'b0;
    logic [MW-1:0]   commit_meta;
    logic [LW-1:0]   commit_data;
    logic            commit_eop;
    logic [3:0]      pending_count;
    logic            err_skew;
    logic            err_underflow;

    int n_run = 0;
    int n_fail = 0;

    vx_tensor_commit_seq dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_meta     (disp_meta),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .unit_data     (unit_data),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_meta   (commit_meta),
        .commit_data   (commit_data),
        .commit_eop    (commit_eop),
        .pending_count (pending_count),
        .err_skew      (err_skew),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Lane word = {tag, beat+1, lane index}.
    function automatic logic [LW-1:0] beat_val(input int tag, input int b);
        logic [LW-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = {8'(tag), 8'(b + 1), 16'(l)};
        return v;
    endfunction

    function automatic logic [NB*LW-1:0] res_val(input int tag);
        logic [NB*LW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*LW +: LW] = beat_val(tag, b);
        return r;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; disp_valid = 1'b0; unit_valid = '0; commit_ready = 1'b0;
        @(negedge clk); #1;
        n_run++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_disp_ready: got %b want 1", disp_ready); end
        n_run++; if (unit_ready !== 4'b0) begin n_fail++; $display("FAIL rst_unit_ready: got %b want 0", unit_ready); end
        n_run++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_commit_valid: got %b want 0", commit_valid); end
        n_run++; if (commit_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop: got %b want 0", commit_eop); end
        n_run++; if (pending_count !== 4'd0) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", pending_count); end
        n_run++; if ({err_skew, err_underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_errs: got %b want 00", {err_skew, err_underflow}); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        @(negedge clk); disp_valid = 1'b1; disp_meta = 64'hA;
        @(negedge clk); disp_meta = 64'hB;
        @(negedge clk); disp_valid = 1'b0; unit_valid = '1; unit_data = res_val(1); #1;
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL basic_join: got %b want 1111", unit_ready); end
        n_run++; if (pending_count !== 4'd2) begin n_fail++; $display("FAIL basic_pend2: got %0d want 2", pending_count); end
        n_run++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_v: got %b want 0", commit_valid); end
        @(negedge clk); unit_valid = '0; commit_ready = 1'b1; #1;
        n_run++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL basic_v0: got %b want 1", commit_valid); end
        n_run++; if (commit_meta !== 64'hA) begin n_fail++; $display("FAIL basic_meta0: got %h want a", commit_meta); end
        n_run++; if (commit_data !== beat_val(1, 0)) begin n_fail++; $display("FAIL basic_data0: got %h want %h", commit_data, beat_val(1, 0)); end
        n_run++; if (commit_eop !== 1'b0) begin n_fail++; $display("FAIL basic_eop0: got %b want 0", commit_eop); end
        @(negedge clk); #1;
        n_run++; if (commit_meta !== 64'hB) begin n_fail++; $display("FAIL basic_meta1: got %h want b", commit_meta); end
        n_run++; if (commit_data !== beat_val(1, 1)) begin n_fail++; $display("FAIL basic_data1: got %h want %h", commit_data, beat_val(1, 1)); end
        n_run++; if (commit_eop !== 1'b1) begin n_fail++; $display("FAIL basic_eop1: got %b want 1", commit_eop); end
        n_run++; if (pending_count !== 4'd1) begin n_fail++; $display("FAIL basic_pend1: got %0d want 1", pending_count); end
        @(negedge clk); commit_ready = 1'b0; #1;
        n_run++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_v: got %b want 0", commit_valid); end
        n_run++; if (pending_count !== 4'd0) begin n_fail++; $display("FAIL basic_pend0: got %0d want 0", pending_count); end
    endtask

    task automatic test_credit;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); disp_valid = 1'b1; disp_meta = 64'h10 + 64'(i); #1;
            n_run++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL credit_rdy%0d: got %b want 1", i, disp_ready); end
        end
        @(negedge clk); disp_meta = 64'h99; #1;
        n_run++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL credit_full_rdy: got %b want 0", disp_ready); end
        n_run++; if (pending_count !== 4'd8) begin n_fail++; $display("FAIL credit_pend8: got %0d want 8", pending_count); end
        @(negedge clk); disp_valid = 1'b0; unit_valid = '1; unit_data = res_val(2); #1;
        n_run++; if (pending_count !== 4'd8) begin n_fail++; $display("FAIL credit_no9th: got %0d want 8", pending_count); end
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL credit_join: got %b want 1111", unit_ready); end
        @(negedge clk); unit_valid = '0; commit_ready = 1'b1; #1;
        n_run++; if (commit_meta !== 64'h10) begin n_fail++; $display("FAIL credit_meta0: got %h want 10", commit_meta); end
        n_run++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL credit_still_full: got %b want 0", disp_ready); end
        @(negedge clk); #1;
        n_run++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL credit_return: got %b want 1", disp_ready); end
        n_run++; if (pending_count !== 4'd7) begin n_fail++; $display("FAIL credit_pend7: got %0d want 7", pending_count); end
        n_run++; if (commit_meta !== 64'h11) begin n_fail++; $display("FAIL credit_meta1: got %h want 11", commit_meta); end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); unit_valid = '1; unit_data = res_val(3 + r); #1;
            n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL drain_join%0d: got %b want 1111", r, unit_ready); end
            @(negedge clk); unit_valid = '0; #1;
            n_run++; if (commit_meta !== 64'h12 + 64'(2 * r)) begin n_fail++; $display("FAIL drain_meta%0d_0: got %h want %h", r, commit_meta, 64'h12 + 64'(2 * r)); end
            n_run++; if (commit_data !== beat_val(3 + r, 0)) begin n_fail++; $display("FAIL drain_data%0d_0: got %h want %h", r, commit_data, beat_val(3 + r, 0)); end
            @(negedge clk); #1;
            n_run++; if (commit_meta !== 64'h13 + 64'(2 * r)) begin n_fail++; $display("FAIL drain_meta%0d_1: got %h want %h", r, commit_meta, 64'h13 + 64'(2 * r)); end
            n_run++; if (commit_eop !== 1'b1) begin n_fail++; $display("FAIL drain_eop%0d: got %b want 1", r, commit_eop); end
        end
        @(negedge clk); commit_ready = 1'b0; #1;
        n_run++; if (pending_count !== 4'd0) begin n_fail++; $display("FAIL drain_pend0: got %0d want 0", pending_count); end
    endtask

    task automatic test_stall;
        @(negedge clk); disp_valid = 1'b1; disp_meta = 64'h21;
        @(negedge clk); disp_meta = 64'h22;
        @(negedge clk); disp_valid = 1'b0; unit_valid = '1; unit_data = res_val(4);
        @(negedge clk); unit_data = res_val(5); #1;
        n_run++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL stall_v: got %b want 1", commit_valid); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_run++; if (commit_meta !== 64'h21) begin n_fail++; $display("FAIL stall_meta%0d: got %h want 21", k, commit_meta); end
            n_run++; if (commit_data !== beat_val(4, 0)) begin n_fail++; $display("FAIL stall_data%0d: got %h want %h", k, commit_data, beat_val(4, 0)); end
            n_run++; if (commit_eop !== 1'b0) begin n_fail++; $display("FAIL stall_eop%0d: got %b want 0", k, commit_eop); end
            n_run++; if (unit_ready !== 4'h0) begin n_fail++; $display("FAIL stall_uready%0d: got %b want 0000", k, unit_ready); end
        end
        @(negedge clk); unit_valid = '0; commit_ready = 1'b1; #1;
        n_run++; if (commit_data !== beat_val(4, 0)) begin n_fail++; $display("FAIL stall_rel0: got %h want %h", commit_data, beat_val(4, 0)); end
        @(negedge clk); #1;
        n_run++; if (commit_meta !== 64'h22) begin n_fail++; $display("FAIL stall_meta1: got %h want 22", commit_meta); end
        n_run++; if (commit_data !== beat_val(4, 1)) begin n_fail++; $display("FAIL stall_rel1: got %h want %h", commit_data, beat_val(4, 1)); end
        n_run++; if (commit_eop !== 1'b1) begin n_fail++; $display("FAIL stall_eop1: got %b want 1", commit_eop); end
        @(negedge clk); commit_ready = 1'b0; #1;
        n_run++; if ({commit_valid, pending_count} !== 5'd0) begin n_fail++; $display("FAIL stall_end: got v=%b p=%0d want v=0 p=0", commit_valid, pending_count); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); disp_valid = 1'b1; disp_meta = 64'h31 + 64'(i);
        end
        @(negedge clk); disp_valid = 1'b0; unit_valid = '1; unit_data = res_val(6); commit_ready = 1'b1; #1;
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL b2b_join0: got %b want 1111", unit_ready); end
        @(negedge clk); unit_data = res_val(7); #1;
        n_run++; if (commit_meta !== 64'h31 || commit_data !== beat_val(6, 0)) begin n_fail++; $display("FAIL b2b_beat0: got meta %h want 31", commit_meta); end
        n_run++; if (unit_ready !== 4'h0) begin n_fail++; $display("FAIL b2b_hold: got %b want 0000", unit_ready); end
        @(negedge clk); #1;
        n_run++; if (commit_meta !== 64'h32 || commit_eop !== 1'b1) begin n_fail++; $display("FAIL b2b_beat1: got meta %h eop %b want 32 1", commit_meta, commit_eop); end
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL b2b_bypass: got %b want 1111", unit_ready); end
        @(negedge clk); unit_valid = '0; #1;
        n_run++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_nobubble: got %b want 1", commit_valid); end
        n_run++; if (commit_meta !== 64'h33 || commit_eop !== 1'b0) begin n_fail++; $display("FAIL b2b_beat2: got meta %h eop %b want 33 0", commit_meta, commit_eop); end
        n_run++; if (commit_data !== beat_val(7, 0)) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", commit_data, beat_val(7, 0)); end
        @(negedge clk); #1;
        n_run++; if (commit_meta !== 64'h34 || commit_data !== beat_val(7, 1)) begin n_fail++; $display("FAIL b2b_beat3: got meta %h want 34", commit_meta); end
        @(negedge clk); commit_ready = 1'b0; #1;
        n_run++; if ({commit_valid, pending_count} !== 5'd0) begin n_fail++; $display("FAIL b2b_end: got v=%b p=%0d want v=0 p=0", commit_valid, pending_count); end
    endtask

    task automatic test_skew;
        @(negedge clk); disp_valid = 1'b1; disp_meta = 64'h41;
        @(negedge clk); disp_meta = 64'h42;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); disp_valid = 1'b0; unit_valid = 4'b0111; #1;
            n_run++; if (unit_ready !== 4'h0) begin n_fail++; $display("FAIL skew_uready%0d: got %b want 0000", k, unit_ready); end
            n_run++; if (err_skew !== 1'b0) begin n_fail++; $display("FAIL skew_early%0d: got %b want 0", k, err_skew); end
        end
        @(negedge clk); unit_valid = '1; unit_data = res_val(8); commit_ready = 1'b1; #1;
        n_run++; if (err_skew !== 1'b1) begin n_fail++; $display("FAIL skew_set: got %b want 1", err_skew); end
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL skew_join: got %b want 1111", unit_ready); end
        @(negedge clk); unit_valid = '0; #1;
        n_run++; if (commit_meta !== 64'h41 || commit_data !== beat_val(8, 0)) begin n_fail++; $display("FAIL skew_beat0: got meta %h want 41", commit_meta); end
        @(negedge clk); #1;
        n_run++; if (commit_meta !== 64'h42 || commit_eop !== 1'b1) begin n_fail++; $display("FAIL skew_beat1: got meta %h eop %b want 42 1", commit_meta, commit_eop); end
        @(negedge clk); commit_ready = 1'b0; #1;
        n_run++; if (err_skew !== 1'b1) begin n_fail++; $display("FAIL skew_sticky: got %b want 1", err_skew); end
        n_run++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL skew_no_uf: got %b want 0", err_underflow); end
    endtask

    task automatic test_underflow;
        @(negedge clk); unit_valid = '1; unit_data = res_val(9); commit_ready = 1'b1; #1;
        n_run++; if (unit_ready !== 4'hF) begin n_fail++; $display("FAIL uf_join: got %b want 1111", unit_ready); end
        @(negedge clk); unit_valid = '0; #1;
        n_run++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL uf_v0: got %b want 0", commit_valid); end
        n_run++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_early: got %b want 0", err_underflow); end
        @(negedge clk); #1;
        n_run++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", err_underflow); end
        n_run++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL uf_v1: got %b want 0", commit_valid); end
        disp_valid = 1'b1; disp_meta = 64'h51;
        @(negedge clk); disp_meta = 64'h52; #1;
        n_run++; if (commit_valid !== 1'b1 || commit_meta !== 64'h51) begin n_fail++; $display("FAIL uf_resume: got v=%b meta %h want 1 51", commit_valid, commit_meta); end
        n_run++; if (commit_data !== beat_val(9, 0)) begin n_fail++; $display("FAIL uf_data0: got %h want %h", commit_data, beat_val(9, 0)); end
        @(negedge clk); disp_valid = 1'b0; #1;
        n_run++; if (commit_meta !== 64'h52 || commit_eop !== 1'b1) begin n_fail++; $display("FAIL uf_beat1: got meta %h eop %b want 52 1", commit_meta, commit_eop); end
        n_run++; if (pending_count !== 4'd1) begin n_fail++; $display("FAIL uf_pend1: got %0d want 1", pending_count); end
        n_run++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; commit_ready = 1'b0; #1;
        n_run++; if (commit_valid !== 1'b0 || commit_eop !== 1'b0) begin n_fail++; $display("FAIL mid_rst_commit: got v=%b eop=%b want 0 0", commit_valid, commit_eop); end
        n_run++; if (pending_count !== 4'd0) begin n_fail++; $display("FAIL mid_rst_pend: got %0d want 0", pending_count); end
        n_run++; if (err_underflow !== 1'b0 || err_skew !== 1'b0) begin n_fail++; $display("FAIL mid_rst_errs: got %b%b want 00", err_skew, err_underflow); end
        n_run++; if (disp_ready !== 1'b1 || unit_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rst_rdy: got %b %b want 1 0000", disp_ready, unit_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_stall();
        test_back_to_back();
        test_skew();
        test_reset();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
